uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one uart_tx byte transmitter between NUM_REQ requesters.
- Each requester submits a 32-bit word plus a byte count (1..4). The block serialises the bytes LSB-first into uart_tx: one i_Tx_DV pulse per byte, then it waits for o_Tx_Done.
- Sits between the bus-side UART register logic / DMA-style producers and the uart_tx instance.

---
 rtl/uart_tx_sched.sv | 151 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx byte transmitter between NUM_REQ requesters.
// Each grant latches a 32-bit word and sends len+1 bytes LSB-first, one tx_dv per byte.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_data,
    input  logic [2*NUM_REQ-1:0]    req_len,
    output logic [NUM_REQ-1:0]      ack,
    output logic [NUM_REQ-1:0]      done,
    output logic                    busy,
    output logic [IDX_W-1:0]        owner,
    output logic                    tx_dv,
    output logic [7:0]              tx_byte,
    input  logic                    tx_active,
    input  logic                    tx_done
);

    localparam int unsigned SLOTS = 2 ** IDX_W;
    localparam int unsigned SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] ack_n, done_n;
    logic               busy_n, tx_dv_n;
    logic [7:0]         tx_byte_n;
    logic [IDX_W-1:0]   owner_n, rr_ptr, rr_n;
    logic [31:0]        word_q, word_n;
    logic [1:0]         len_q, len_n, idx_q, idx_n;

    logic [SLOTS-1:0]   req_ext;
    logic [31:0]        data_arr [SLOTS];
    logic [1:0]         len_arr  [SLOTS];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx, cand;
    logic [SUM_W-1:0]   sum;

    // Pad requester buses out to the full index range so selects need no bounds logic
    assign req_ext = SLOTS'(req);

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        if (g < NUM_REQ) begin : g_used
            assign data_arr[g] = req_data[32*g +: 32];
            assign len_arr[g]  = req_len[2*g +: 2];
        end else begin : g_unused
            assign data_arr[g] = '0;
            assign len_arr[g]  = '0;
        end
    end

    // First set request at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = SUM_W'(rr_ptr) + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!win_found && req_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ack     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            owner   <= '0;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
            rr_ptr  <= '0;
            word_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state   <= state_n;
            ack     <= ack_n;
            done    <= done_n;
            busy    <= busy_n;
            owner   <= owner_n;
            tx_dv   <= tx_dv_n;
            tx_byte <= tx_byte_n;
            rr_ptr  <= rr_n;
            word_q  <= word_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n   = state;
        ack_n     = '0;
        done_n    = '0;
        tx_dv_n   = 1'b0;
        tx_byte_n = tx_byte;
        owner_n   = owner;
        rr_n      = rr_ptr;
        word_n    = word_q;
        len_n     = len_q;
        idx_n     = idx_q;
        case (state)
            IDLE: begin
                if (win_found) begin
                    ack_n   = NUM_REQ'(1) << win_idx;
                    owner_n = win_idx;
                    word_n  = data_arr[win_idx];
                    len_n   = len_arr[win_idx];
                    idx_n   = '0;
                    rr_n    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    state_n = SEND;
                end
            end
            SEND: begin
                if (!tx_active) begin
                    tx_dv_n   = 1'b1;
                    tx_byte_n = 8'(word_q >> {idx_q, 3'b000});
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (idx_q != len_q) begin
                        idx_n   = idx_q + 2'd1;
                        state_n = SEND;
                    end else begin
                        done_n  = NUM_REQ'(1) << owner;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Busy spans the ack cycle through the done cycle
        busy_n = (state_n != IDLE) || (|done_n);
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural uart_tx (CLKS_PER_BIT=4)
// and a byte scoreboard filled when requests are driven.
module tb_uart_tx_sched;

    localparam int NUM_REQ      = 2;
    localparam int IDX_W        = 3;
    localparam int CLKS_PER_BIT = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [32*NUM_REQ-1:0] req_data = '0;
    logic [2*NUM_REQ-1:0]  req_len = '0;
    logic [NUM_REQ-1:0]    ack, done;
    logic                  busy, tx_dv;
    logic [IDX_W-1:0]      owner;
    logic [7:0]            tx_byte;
    logic                  tx_active = 1'b0;
    logic                  tx_done = 1'b0;
    logic                  force_active = 1'b0;

    uart_tx_sched #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_len(req_len),
        .ack(ack), .done(done), .busy(busy), .owner(owner), .tx_dv(tx_dv),
        .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, dv_cnt = 0, activity = 0, busy_gap = 0, line_cnt = 0;
    int txdone_cyc = -100, ack_cyc = -100, first_dv_cyc = -1;
    bit in_xfer = 1'b0;
    logic [7:0] exp_q[$];
    int ack_log[$];
    int done_log[$];

    typedef struct {
        int          who;
        logic [31:0] data;
        logic [1:0]  len;
        int          nbytes;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // uart_tx model: 10 bit times on the line, tx_done pulse as the line frees
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (line_cnt > 0) begin
            line_cnt--;
            if (line_cnt == 0) begin
                tx_done    = 1'b1;
                txdone_cyc = cyc;
            end
        end else if (tx_dv) begin
            line_cnt = 10 * CLKS_PER_BIT;
        end
        tx_active = (line_cnt > 0) || force_active;
    end

    // Monitor: sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (reset) in_xfer = 1'b0;
        if (tx_dv || (|ack) || (|done) || busy) activity++;
        if (tx_dv) begin
            dv_cnt++;
            if (first_dv_cyc < 0) first_dv_cyc = cyc;
            chk("dv_line_idle", 32'(tx_active), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dv_unexpected: byte %h sent with nothing expected (cycle %0d)", tx_byte, cyc);
            end else begin
                chk("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
            end
        end
        if (|ack) begin
            ack_log.push_back(oh_idx(ack));
            ack_cyc      = cyc;
            first_dv_cyc = -1;
            in_xfer      = 1'b1;
            chk("ack_onehot", 32'($countones(ack)), 32'd1);
            chk("owner_at_ack", 32'(owner), 32'(oh_idx(ack)));
            chk("busy_at_ack", 32'(busy), 32'd1);
        end
        if (|done) begin
            done_log.push_back(oh_idx(done));
            in_xfer = 1'b0;
            chk("done_after_txdone", 32'(cyc - txdone_cyc), 32'd1);
        end else if (in_xfer && !busy) begin
            busy_gap++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_req(input int who, input logic v, input logic [31:0] data, input logic [1:0] len);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == who) begin
                req[i]               = v;
                req_data[32*i +: 32] = data;
                req_len[2*i +: 2]    = len;
            end
        end
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int t = 0;
        while (ack_log.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        if (ack_log.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_ack_timeout: acks %0d wanted %0d", tag, ack_log.size(), n);
        end
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int t = 0;
        while (done_log.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        if (done_log.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_done_timeout: dones %0d wanted %0d", tag, done_log.size(), n);
        end
    endtask

    task automatic wait_dv(input int n, input int budget, input string tag);
        int t = 0;
        while (dv_cnt < n && t < budget) begin
            tick(1);
            t++;
        end
        if (dv_cnt < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_dv_timeout: tx_dv %0d wanted %0d", tag, dv_cnt, n);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tx_dv"}, 32'(tx_dv), 32'd0);
        chk({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
        chk_outputs_zero(tag);
    endtask

    task automatic run_single(input int who, input logic [31:0] data, input logic [1:0] len,
                              input int nbytes, input string tag);
        int a0 = ack_log.size();
        int d0 = done_log.size();
        int v0 = dv_cnt;
        int g0 = busy_gap;
        int rc;
        for (int b = 0; b <= int'(len); b++) exp_q.push_back(data[8*b +: 8]);
        set_req(who, 1'b1, data, len);
        rc = cyc;
        wait_acks(a0 + 1, 10, tag);
        chk({tag, "_ack_latency"}, 32'(ack_cyc - rc), 32'd1);
        if (ack_log.size() > a0) chk({tag, "_ack_who"}, 32'(ack_log[a0]), 32'(who));
        set_req(who, 1'b0, data, len);
        wait_dones(d0 + 1, 60 * nbytes + 50, tag);
        if (done_log.size() > d0) chk({tag, "_done_who"}, 32'(done_log[d0]), 32'(who));
        chk({tag, "_dv_count"}, 32'(dv_cnt - v0), 32'(nbytes));
        chk({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy_held"}, 32'(busy_gap - g0), 32'd0);
        chk({tag, "_dv_after_ack"}, 32'(first_dv_cyc - ack_cyc >= 1), 32'd1);
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0, v0, act0;
        vecs[0] = '{0, 32'hA1B2C3D4, 2'd3, 4};
        vecs[1] = '{1, 32'h0000005A, 2'd0, 1};
        vecs[2] = '{0, 32'h00BEEF77, 2'd2, 3};
        vecs[3] = '{1, 32'h12348001, 2'd1, 2};

        // Reset, then idle quiet
        tick(1);
        do_reset("reset");
        act0 = activity;
        tick(100);
        chk("idle_quiet", 32'(activity - act0), 32'd0);

        // Single-requester transfers from the table
        foreach (vecs[i]) run_single(vecs[i].who, vecs[i].data, vecs[i].len, vecs[i].nbytes,
                                     $sformatf("vec%0d", i));

        // Both requesting continuously: grants alternate 0,1,0,1
        do_reset("rr_reset");
        a0 = ack_log.size();
        d0 = done_log.size();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        set_req(0, 1'b1, 32'h00000011, 2'd0);
        set_req(1, 1'b1, 32'h00000022, 2'd0);
        wait_acks(a0 + 4, 400, "rr");
        req = '0;
        wait_dones(d0 + 4, 400, "rr");
        for (int i = 0; i < 4; i++) begin
            if (ack_log.size() > a0 + i) chk($sformatf("rr_ack%0d", i), 32'(ack_log[a0+i]), 32'(i % 2));
        end
        chk("rr_bytes_left", 32'(exp_q.size()), 32'd0);
        tick(2);

        // Line held busy: ack goes out, tx_dv waits for the line
        force_active = 1'b1;
        tick(2);
        a0 = ack_log.size();
        d0 = done_log.size();
        v0 = dv_cnt;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        set_req(1, 1'b1, 32'h0000BEEF, 2'd1);
        wait_acks(a0 + 1, 10, "stall");
        if (ack_log.size() > a0) chk("stall_ack_who", 32'(ack_log[a0]), 32'd1);
        set_req(1, 1'b0, 32'h0000BEEF, 2'd1);
        tick(45);
        chk("stall_dv_withheld", 32'(dv_cnt - v0), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        force_active = 1'b0;
        wait_dones(d0 + 1, 200, "stall");
        chk("stall_dv_count", 32'(dv_cnt - v0), 32'd2);
        chk("stall_bytes_left", 32'(exp_q.size()), 32'd0);
        tick(2);

        // Reset while waiting on the 2nd byte of a 4-byte transfer
        a0 = ack_log.size();
        v0 = dv_cnt;
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h88 - 8'(b * 8'h11));
        set_req(1, 1'b1, 32'h55667788, 2'd3);
        wait_acks(a0 + 1, 10, "abort");
        set_req(1, 1'b0, 32'h55667788, 2'd3);
        wait_dv(v0 + 2, 200, "abort");
        tick(3);
        d0 = done_log.size();
        reset = 1'b1;
        tick(1);
        chk_outputs_zero("abort_reset");
        reset = 1'b0;
        exp_q.delete();
        run_single(0, 32'hCAFEF00D, 2'd1, 2, "post_reset");
        chk("abort_no_done", 32'(done_log.size() - d0), 32'd1);

        // One-cycle req pulse while busy is never served
        a0 = ack_log.size();
        d0 = done_log.size();
        v0 = dv_cnt;
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h3C - 8'(b * 8'h0F));
        set_req(0, 1'b1, 32'h0F1E2D3C, 2'd3);
        wait_acks(a0 + 1, 10, "pulse");
        set_req(0, 1'b0, 32'h0F1E2D3C, 2'd3);
        tick(3);
        set_req(1, 1'b1, 32'h99999999, 2'd0);
        tick(1);
        set_req(1, 1'b0, 32'h99999999, 2'd0);
        wait_dones(d0 + 1, 400, "pulse");
        tick(60);
        chk("pulse_ack_count", 32'(ack_log.size() - a0), 32'd1);
        if (ack_log.size() > a0) chk("pulse_ack_who", 32'(ack_log[a0]), 32'd0);
        chk("pulse_dv_count", 32'(dv_cnt - v0), 32'd4);
        chk("pulse_bytes_left", 32'(exp_q.size()), 32'd0);
        chk("pulse_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
